// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the multicycle MIPS datapath.
//   DEFAULT_WIDTH : default operand width of the multiply/divide unit
//   op_e          : mult/div operation select encodings
//   state_e       : multiply/divide unit FSM states
package cpu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_DIV   = 2'b01,
        OP_MULTU = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIN  = 2'b10
    } state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/result bundle between the control unit / operand
// registers (master) and the multiply/divide unit (slave).
//   start, op, a, b        : request (master -> slave)
//   busy, done, div_zero   : status  (slave -> master)
//   hi, lo                 : HI/LO result registers (slave -> master)
interface mult_div_unit_if #(
    parameter int WIDTH = cpu_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed multiply (radix-2 Booth) and restoring
// divide, WIDTH iterations plus one result cycle. Quotient/low product to lo,
// remainder/high product to hi. Divide by zero finishes after one cycle with
// div_zero and leaves hi/lo untouched.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : mult_div_unit_if.slave (start, op, a, b -> busy, done, div_zero, hi, lo)
// Build option: define MULTDIV_UNSIGNED_EN to make op 10/11 unsigned multu/divu;
// otherwise op[1] is ignored.
module mult_div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`ifdef MULTDIV_UNSIGNED_EN
    localparam logic UNS_EN = 1'b1;
`else
    localparam logic UNS_EN = 1'b0;
`endif

    state_e           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic             is_div, zf, corr, neg_q, neg_r;
    logic [WIDTH:0]   opnd;      // sign/zero-extended multiplicand, or divisor magnitude
    logic [WIDTH:0]   acc_u;     // Booth upper partial product / division remainder
    logic [WIDTH-1:0] acc_l;     // multiplier bits / dividend-then-quotient bits
    logic             acc_q;     // Booth q(-1) bit
    logic [WIDTH-1:0] hi_r, lo_r;

    // Request decode (only meaningful in the start cycle)
    logic             in_div, in_uns, in_b_zero;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign in_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    assign in_uns    = bus.op[1] & UNS_EN;
    assign in_b_zero = (bus.b == '0);
    assign a_mag     = (!in_uns && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag     = (!in_uns && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // One iteration of each datapath, plus the final result formatting
    logic [WIDTH:0]   booth_sum, m_u_nxt, d_shift, d_u_nxt;
    logic [WIDTH+1:0] d_diff;
    logic [WIDTH-1:0] m_l_nxt, d_l_nxt, r_mag, res_hi, res_lo;

    always_comb begin
        booth_sum = acc_u;
        case ({acc_l[0], acc_q})
            2'b01:   booth_sum = acc_u + opnd;
            2'b10:   booth_sum = acc_u - opnd;
            default: booth_sum = acc_u;
        endcase
        m_u_nxt = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        m_l_nxt = {booth_sum[0], acc_l[WIDTH-1:1]};

        d_shift = {acc_u[WIDTH-1:0], acc_l[WIDTH-1]};
        d_diff  = {1'b0, d_shift} - {1'b0, opnd};
        if (!d_diff[WIDTH+1]) begin
            d_u_nxt = d_diff[WIDTH:0];
            d_l_nxt = {acc_l[WIDTH-2:0], 1'b1};
        end else begin
            d_u_nxt = d_shift;
            d_l_nxt = {acc_l[WIDTH-2:0], 1'b0};
        end
        r_mag = d_u_nxt[WIDTH-1:0];

        if (is_div) begin
            res_lo = neg_q ? -d_l_nxt : d_l_nxt;
            res_hi = neg_r ? -r_mag : r_mag;
        end else begin
            // Booth treats the multiplier as signed; for multu with its MSB set
            // the product is short by multiplicand * 2^WIDTH.
            res_lo = m_l_nxt;
            res_hi = m_u_nxt[WIDTH-1:0] + (corr ? opnd[WIDTH-1:0] : '0);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = (in_div && in_b_zero) ? S_FIN : S_CALC;
            S_CALC:  if (cnt == '0) state_nxt = S_FIN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            zf     <= 1'b0;
            corr   <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            opnd   <= '0;
            acc_u  <= '0;
            acc_l  <= '0;
            acc_q  <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        is_div <= in_div;
                        zf     <= in_div && in_b_zero;
                        corr   <= !in_div && in_uns && bus.b[WIDTH-1];
                        neg_q  <= in_div && !in_uns && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_r  <= in_div && !in_uns && bus.a[WIDTH-1];
                        cnt    <= CW'(WIDTH - 1);
                        acc_u  <= '0;
                        acc_q  <= 1'b0;
                        if (in_div) begin
                            opnd  <= {1'b0, b_mag};
                            acc_l <= a_mag;
                        end else begin
                            opnd  <= {~in_uns & bus.a[WIDTH-1], bus.a};
                            acc_l <= bus.b;
                        end
                    end
                end
                S_CALC: begin
                    cnt <= cnt - 1'b1;
                    if (is_div) begin
                        acc_u <= d_u_nxt;
                        acc_l <= d_l_nxt;
                    end else begin
                        acc_u <= m_u_nxt;
                        acc_l <= m_l_nxt;
                        acc_q <= acc_l[0];
                    end
                    if (cnt == '0) begin
                        hi_r <= res_hi;
                        lo_r <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state == S_CALC);
    assign bus.done     = (state == S_FIN);
    assign bus.div_zero = (state == S_FIN) && zf;
    assign bus.hi       = hi_r;
    assign bus.lo       = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed table-driven bench for mult_div_unit plus
// hand-written sequences for ignored starts and mid-operation reset.
// Expected results for op 10/11 follow MULTDIV_UNSIGNED_EN.
module tb_mult_div_unit;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string name, input logic [1:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] hi, input logic [31:0] lo,
                                input logic dz, input int cyc);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b;
        v.hi = hi; v.lo = lo; v.dz = dz; v.cyc = cyc;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one start in cycle 0 and follow the operation to its done pulse.
    task automatic run_op(input vec_t v);
        int          done_cyc = 0;
        logic [31:0] ghi = '0;
        logic [31:0] glo = '0;
        logic        gdz = 1'b0;
        logic        busy_ok = 1'b1;
        @(negedge clk);
        bus.start = 1'b1; bus.op = v.op; bus.a = v.a; bus.b = v.b;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.op = 2'($urandom);
            bus.a  = $urandom;
            bus.b  = $urandom;
            if (bus.done === 1'b1) begin
                done_cyc = c;
                ghi = bus.hi; glo = bus.lo; gdz = bus.div_zero;
                if (bus.busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
        end
        check({v.name, " done_cycle"}, 64'(done_cyc), 64'(v.cyc));
        check({v.name, " hi"}, 64'(ghi), 64'(v.hi));
        check({v.name, " lo"}, 64'(glo), 64'(v.lo));
        check({v.name, " div_zero"}, 64'(gdz), 64'(v.dz));
        check({v.name, " busy"}, 64'(busy_ok), 64'(1'b1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   done_cnt;
        int   done_at;
        logic busy_bad;
        vec_t fresh;

        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        reset = 1'b0;

        add("mult 7*-3",        2'b00, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33);
        add("mult min*min",     2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33);
        add("mult 0*x",         2'b00, 32'd0,        32'h12345678, 32'h00000000, 32'h00000000, 1'b0, 33);
        add("mult 0x12345*2^16",2'b00, 32'h00012345, 32'h00010000, 32'h00000001, 32'h23450000, 1'b0, 33);
        add("mult -1*max",      2'b00, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0, 33);
        add("mult max*max",     2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 33);
        add("mult min*1",       2'b00, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000, 1'b0, 33);
        add("div -7/2",         2'b01, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
        add("div min/-1",       2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33);
        add("div 100/7",        2'b01, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33);
        add("div 7/-2",         2'b01, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 33);
        add("div -7/-2",        2'b01, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        1'b0, 33);
        add("div 3/10",         2'b01, 32'd3,        32'd10,       32'd3,        32'd0,        1'b0, 33);
        add("div 0x451/0x20",   2'b01, 32'h451,      32'h20,       32'h11,       32'h22,       1'b0, 33);
        add("div 5/0",          2'b01, 32'd5,        32'd0,        32'h11,       32'h22,       1'b1, 1);
        add("op11 9/0",         2'b11, 32'd9,        32'd0,        32'h11,       32'h22,       1'b1, 1);
`ifdef MULTDIV_UNSIGNED_EN
        add("op10 ffff*ffff",   2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
        add("op10 ffff*2",      2'b10, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 1'b0, 33);
        add("op11 ffff/2",      2'b11, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'h7FFFFFFF, 1'b0, 33);
        add("op11 min/ffff",    2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 33);
`else
        add("op10 ffff*ffff",   2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33);
        add("op10 ffff*2",      2'b10, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33);
        add("op11 ffff/2",      2'b11, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'h00000000, 1'b0, 33);
        add("op11 min/ffff",    2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33);
`endif

        // Reset state
        #12;
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset div_zero", 64'(bus.div_zero), 64'd0);
        check("reset hi", 64'(bus.hi), 64'd0);
        check("reset lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) run_op(vecs[i]);

        // A start at cycle 10 (busy) and at cycle 33 (FIN) must both be ignored;
        // the ignored requests are div-by-zero so acceptance would show a done.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd7; bus.b = 32'hFFFFFFFD;
        done_cnt = 0; done_at = 0; busy_bad = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_at == 0) begin
                    done_at = c;
                    check("restart hi", 64'(bus.hi), 64'hFFFFFFFF);
                    check("restart lo", 64'(bus.lo), 64'hFFFFFFEB);
                end
            end
            if (c == 34 && bus.busy !== 1'b0) busy_bad = 1'b1;
            bus.start = (c == 10 || c == 33);
            bus.op = 2'b01; bus.a = 32'h12345678; bus.b = 32'd0;
        end
        bus.start = 1'b0;
        check("restart done_count", 64'(done_cnt), 64'd1);
        check("restart done_cycle", 64'(done_at), 64'd33);
        check("start in FIN busy", 64'(busy_bad), 64'd0);

        // Reset at cycle 15 aborts without a done and clears hi/lo.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'h1234; bus.b = 32'h5678;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        reset = 1'b0;
        #1;
        check("midreset busy", 64'(bus.busy), 64'd0);
        check("midreset hi", 64'(bus.hi), 64'd0);
        check("midreset lo", 64'(bus.lo), 64'd0);
        check("midreset done", 64'(bus.done), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        done_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_cnt++;
        end
        check("midreset no_done", 64'(done_cnt), 64'd0);

        fresh.name = "post-reset mult"; fresh.op = 2'b00;
        fresh.a = 32'h1234; fresh.b = 32'h5678;
        fresh.hi = 32'h0; fresh.lo = 32'h06260060; fresh.dz = 1'b0; fresh.cyc = 33;
        run_op(fresh);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
